ipsl_pcie_dma_rx_mwr_parser: RTL

//  RX TLP front end for the DMA controller's MWr write path. Consumes the PCIe core's 128-bit RX AXI-stream,

---
 rtl/ipsl_pcie_dma_pkg.sv | 43 ++++
 rtl/ipsl_pcie_dma_rx_mwr_parser.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ipsl_pcie_dma_pkg.sv
// Shared definitions for the PCIe DMA RX path.
//  - TLP header field positions within the first 128-bit beat (DW0 in [31:0] .. DW3 in [127:96])
//  - fmt/type constants used to recognise Memory Write TLPs
//  - BAR index constants for the tuser BAR-hit vector
//  - RX parser FSM state type and a 4-bit popcount helper
package ipsl_pcie_dma_pkg;

    // fmt[1] = TLP carries data, fmt[0] = 4DW header
    localparam int unsigned FMT_HAS_DATA = 1;
    localparam int unsigned FMT_4DW      = 0;
    localparam logic [4:0]  TYPE_MEM     = 5'b00000;

    // Header field positions in the first beat
    localparam int unsigned FMT_MSB  = 30;
    localparam int unsigned FMT_LSB  = 29;
    localparam int unsigned TYPE_MSB = 28;
    localparam int unsigned TYPE_LSB = 24;
    localparam int unsigned LEN_MSB  = 9;
    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned BE_MSB   = 39;
    localparam int unsigned BE_LSB   = 32;
    localparam int unsigned DW2_LSB  = 64;
    localparam int unsigned DW3_LSB  = 96;

    localparam int unsigned BAR0 = 0;
    localparam int unsigned BAR1 = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StDrop = 2'd2
    } rx_state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Length field of 0 encodes 1024 DW
    function automatic logic [10:0] exp_len(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

endpackage

// File: rtl/ipsl_pcie_dma_rx_mwr_parser.sv
// RX TLP front end for the DMA MWr write path.
// Consumes the 128-bit RX AXI-stream, decodes each TLP header and forwards only
// Memory Writes that hit an enabled BAR; every other TLP is consumed and dropped.
// All outputs are registered, one cycle behind the accepted beat.
// Ports:
//  clk, rst            core clock, asynchronous active-high reset
//  i_axis_*            RX stream (tuser[1:0] = BAR hit one-hot)
//  o_axis_tready       1 from the first edge after reset release, never deasserted
//  o_mwr_wr_start      pulse on the first output beat of an accepted MWr
//  o_mwr_length/dwbe/addr, o_bar_hit   header info, held until the next start
//  o_mwr_data/dw_vld   payload beat and per-DW lane valid
//  o_len_err           pulse when the forwarded DW count differs from the length field
//  o_drop              pulse per dropped TLP, on its header beat
module ipsl_pcie_dma_rx_mwr_parser
    import ipsl_pcie_dma_pkg::*;
#(
    parameter logic [1:0] BAR_MASK = 2'b11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_axis_tvalid,
    output logic         o_axis_tready,
    input  logic [127:0] i_axis_tdata,
    input  logic [3:0]   i_axis_tkeep,
    input  logic         i_axis_tlast,
    input  logic [7:0]   i_axis_tuser,
    output logic         o_mwr_wr_start,
    output logic [9:0]   o_mwr_length,
    output logic [7:0]   o_mwr_dwbe,
    output logic [63:0]  o_mwr_addr,
    output logic [127:0] o_mwr_data,
    output logic [3:0]   o_mwr_dw_vld,
    output logic [1:0]   o_bar_hit,
    output logic         o_len_err,
    output logic         o_drop
);

    rx_state_e   state;
    logic [10:0] dw_cnt;

    logic        beat;
    logic [1:0]  hdr_fmt;
    logic [4:0]  hdr_type;
    logic [9:0]  hdr_len;
    logic        hdr_is_mwr;
    logic        hdr_4dw;
    logic        hdr_accept;
    logic [31:0] hdr_dw2;
    logic [31:0] hdr_dw3;
    logic [63:0] hdr_addr;
    logic [3:0]  hdr_vld;
    logic [10:0] hdr_cnt;
    logic [10:0] data_cnt;
    logic        unused_tuser;

    assign beat       = i_axis_tvalid & o_axis_tready;
    assign hdr_fmt    = i_axis_tdata[FMT_MSB:FMT_LSB];
    assign hdr_type   = i_axis_tdata[TYPE_MSB:TYPE_LSB];
    assign hdr_len    = i_axis_tdata[LEN_MSB:LEN_LSB];
    assign hdr_dw2    = i_axis_tdata[DW2_LSB +: 32];
    assign hdr_dw3    = i_axis_tdata[DW3_LSB +: 32];
    assign hdr_is_mwr = hdr_fmt[FMT_HAS_DATA] && (hdr_type == TYPE_MEM);
    assign hdr_4dw    = hdr_fmt[FMT_4DW];
    assign hdr_accept = hdr_is_mwr && |(i_axis_tuser[1:0] & BAR_MASK);
    assign hdr_addr   = hdr_4dw ? {hdr_dw2, hdr_dw3[31:2], 2'b00}
                                : {32'h0, hdr_dw2[31:2], 2'b00};
    // A 3DW header beat carries the first payload DW in lane 3
    assign hdr_vld    = hdr_4dw ? 4'b0000 : (4'b1000 & i_axis_tkeep);
    assign hdr_cnt    = {8'h00, popcount4(hdr_vld)};
    assign data_cnt   = dw_cnt + {8'h00, popcount4(i_axis_tkeep)};

    assign unused_tuser = ^i_axis_tuser[7:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            dw_cnt         <= 11'd0;
            o_axis_tready  <= 1'b0;
            o_mwr_wr_start <= 1'b0;
            o_mwr_length   <= 10'd0;
            o_mwr_dwbe     <= 8'h00;
            o_mwr_addr     <= 64'h0;
            o_mwr_data     <= 128'h0;
            o_mwr_dw_vld   <= 4'h0;
            o_bar_hit      <= 2'b00;
            o_len_err      <= 1'b0;
            o_drop         <= 1'b0;
        end else begin
            o_axis_tready  <= 1'b1;
            o_mwr_wr_start <= 1'b0;
            o_mwr_dw_vld   <= 4'h0;
            o_len_err      <= 1'b0;
            o_drop         <= 1'b0;
            if (beat) begin
                o_mwr_data <= i_axis_tdata;
            end
            case (state)
                StIdle: begin
                    if (beat) begin
                        if (hdr_accept) begin
                            o_mwr_wr_start <= 1'b1;
                            o_mwr_length   <= hdr_len;
                            o_mwr_dwbe     <= i_axis_tdata[BE_MSB:BE_LSB];
                            o_mwr_addr     <= hdr_addr;
                            o_bar_hit      <= i_axis_tuser[1:0];
                            o_mwr_dw_vld   <= hdr_vld;
                            dw_cnt         <= hdr_cnt;
                            if (i_axis_tlast) begin
                                // Single-beat TLP: a 4DW header here always mismatches
                                o_len_err <= (hdr_cnt != exp_len(hdr_len));
                            end else begin
                                state <= StData;
                            end
                        end else begin
                            o_drop <= 1'b1;
                            if (!i_axis_tlast) begin
                                state <= StDrop;
                            end
                        end
                    end
                end
                StData: begin
                    if (beat) begin
                        o_mwr_dw_vld <= i_axis_tkeep;
                        dw_cnt       <= data_cnt;
                        if (i_axis_tlast) begin
                            o_len_err <= (data_cnt != exp_len(o_mwr_length));
                            state     <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (beat && i_axis_tlast) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
